// File: rtl/fan_speed_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fan_speed_pkg
// Purpose  : Shared types, default thresholds and the level-to-thermometer
//            decode used by the fan speed controller.
// Contents : fan_level_t (3-bit level 0..4), DEF_* default constants,
//            level_to_therm() function.
// Revision : 1.0 - initial release
// ============================================================================
package fan_speed_pkg;

   typedef logic [2:0] fan_level_t;

   localparam fan_level_t  LEVEL_MAX    = 3'd4;

   localparam int unsigned DEF_TH1      = 8;
   localparam int unsigned DEF_TH2      = 10;
   localparam int unsigned DEF_TH3      = 12;
   localparam int unsigned DEF_TH4      = 13;
   localparam int unsigned DEF_HYST     = 1;
   localparam int unsigned DEF_RAMP_DIV = 4;
   localparam int unsigned DEF_OVT      = 15;

   // One drive stage per level; codes above 4 cannot occur but decode to
   // full drive so a corrupted level fails safe (fan on).
   function automatic logic [3:0] level_to_therm(input fan_level_t lvl);
      logic [3:0] therm;
      case (lvl)
         3'd0:    therm = 4'b0000;
         3'd1:    therm = 4'b0001;
         3'd2:    therm = 4'b0011;
         3'd3:    therm = 4'b0111;
         default: therm = 4'b1111;
      endcase
      return therm;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fan_level_target.sv
`default_nettype none
// ============================================================================
// Module   : fan_level_target
// Purpose  : Combinational target-level computation with step-down
//            hysteresis. Stepping up uses the raw thresholds; holding or
//            stepping down compares temp + HYST so a level is only left
//            once temp drops below THk - HYST.
// Ports    : temp   [3:0] in  - temperature code
//            level  [2:0] in  - current fan level
//            target [2:0] out - level the ramp should move toward
// Revision : 1.0 - initial release
// ============================================================================
module fan_level_target
   import fan_speed_pkg::*;
#(
   parameter int unsigned TH1  = DEF_TH1,
   parameter int unsigned TH2  = DEF_TH2,
   parameter int unsigned TH3  = DEF_TH3,
   parameter int unsigned TH4  = DEF_TH4,
   parameter int unsigned HYST = DEF_HYST
) (
   input  logic [3:0] temp,
   input  fan_level_t level,
   output fan_level_t target
);

   // Index 0 is the implicit TH0 = 0, always satisfied.
   localparam logic [4:0] c_th_tab [0:4] = '{5'd0, 5'(TH1), 5'(TH2), 5'(TH3), 5'(TH4)};

   // 5-bit sum: HYST < TH1 <= 15 keeps temp + HYST below 32, no wrap.
   logic [4:0] w_temp_ext;
   logic [4:0] w_temp_hyst;
   fan_level_t w_up;
   fan_level_t w_hold;

   assign w_temp_ext  = {1'b0, temp};
   assign w_temp_hyst = w_temp_ext + 5'(HYST);

   always_comb begin
      w_up   = '0;
      w_hold = '0;
      for (int k = 1; k < 5; k++) begin
         if (w_temp_ext >= c_th_tab[k]) begin
            w_up = fan_level_t'(k);
         end
         if ((fan_level_t'(k) <= level) && (w_temp_hyst >= c_th_tab[k])) begin
            w_hold = fan_level_t'(k);
         end
      end
   end

   assign target = (w_up > level) ? w_up : w_hold;

endmodule
`default_nettype wire

// File: rtl/fan_speed_cont.sv
`default_nettype none
// ============================================================================
// Module   : fan_speed_cont
// Purpose  : Maps a 4-bit temperature code to a five-level thermometer fan
//            drive with step-down hysteresis and a rate-limited ramp (one
//            level per RAMP_DIV clocks).
// Ports    : clk          in  - system clock, rising edge
//            rst_n        in  - asynchronous active-low reset
//            temp   [3:0] in  - temperature code, sampled every edge
//            fan_out[3:0] out - thermometer drive decoded from level
//            overtemp     out - (optional) registered temp >= OVT flag
// Options  : FAN_SPEED_CONT_OVERTEMP_EN - adds OVT parameter and overtemp
//            output; temp >= OVT forces level 4 immediately.
// Revision : 1.0 - initial release
// ============================================================================
module fan_speed_cont
   import fan_speed_pkg::*;
#(
   parameter int unsigned TH1      = DEF_TH1,
   parameter int unsigned TH2      = DEF_TH2,
   parameter int unsigned TH3      = DEF_TH3,
   parameter int unsigned TH4      = DEF_TH4,
   parameter int unsigned HYST     = DEF_HYST,
   parameter int unsigned RAMP_DIV = DEF_RAMP_DIV
`ifdef FAN_SPEED_CONT_OVERTEMP_EN
   ,
   parameter int unsigned OVT      = DEF_OVT
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] temp,
   output logic [3:0] fan_out
`ifdef FAN_SPEED_CONT_OVERTEMP_EN
   ,
   output logic       overtemp
`endif
);

   // Parameter legality is checked while elaborating.
   if (!((TH1 < TH2) && (TH2 < TH3) && (TH3 < TH4) && (TH4 <= 15) && (HYST < TH1)))
   begin : g_bad_thresholds
      $error("fan_speed_cont: thresholds must satisfy TH1<TH2<TH3<TH4<=15 and HYST<TH1");
   end
   if ((RAMP_DIV < 1) || (RAMP_DIV > 255)) begin : g_bad_ramp_div
      $error("fan_speed_cont: RAMP_DIV must be in 1..255");
   end

   localparam logic [7:0] c_ramp_last = 8'(RAMP_DIV - 1);

   fan_level_t level_q,    level_d;
   logic [7:0] ramp_cnt_q, ramp_cnt_d;
   fan_level_t w_target;

   fan_level_target #(
      .TH1  (TH1),
      .TH2  (TH2),
      .TH3  (TH3),
      .TH4  (TH4),
      .HYST (HYST)
   ) u_target (
      .temp   (temp),
      .level  (level_q),
      .target (w_target)
   );

`ifdef FAN_SPEED_CONT_OVERTEMP_EN
   logic overtemp_q, overtemp_d;
`endif

   always_comb begin
      level_d    = level_q;
      ramp_cnt_d = ramp_cnt_q;
      if (w_target == level_q) begin
         ramp_cnt_d = '0;
      end else if (ramp_cnt_q == c_ramp_last) begin
         // Counter is not cleared on a target reversal, so the step taken
         // here always heads toward whatever the target is right now.
         ramp_cnt_d = '0;
         level_d    = (w_target > level_q) ? (level_q + 3'd1) : (level_q - 3'd1);
      end else begin
         ramp_cnt_d = ramp_cnt_q + 8'd1;
      end
`ifdef FAN_SPEED_CONT_OVERTEMP_EN
      overtemp_d = ({1'b0, temp} >= 5'(OVT));
      if (overtemp_d) begin
         level_d    = LEVEL_MAX;
         ramp_cnt_d = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q    <= '0;
         ramp_cnt_q <= '0;
`ifdef FAN_SPEED_CONT_OVERTEMP_EN
         overtemp_q <= 1'b0;
`endif
      end else begin
         level_q    <= level_d;
         ramp_cnt_q <= ramp_cnt_d;
`ifdef FAN_SPEED_CONT_OVERTEMP_EN
         overtemp_q <= overtemp_d;
`endif
      end
   end

   // Pure decode of the register: changes only on a clock edge or reset.
   assign fan_out = level_to_therm(level_q);

`ifdef FAN_SPEED_CONT_OVERTEMP_EN
   assign overtemp = overtemp_q;
`endif

`ifndef SYNTHESIS
   a_temp_known : assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(temp))
      else $error("fan_speed_cont: temp is unknown");
`endif

endmodule
`default_nettype wire

// File: tb/tb_fan_speed_cont.sv
`default_nettype none
// ============================================================================
// Module   : tb_fan_speed_cont
// Purpose  : Self-checking bench for fan_speed_cont: directed scenarios with
//            fixed expected codes plus randomized temp sequences compared
//            against a behavioural model of the threshold/ramp rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fan_speed_cont;

   localparam int TH1      = 8;
   localparam int TH2      = 10;
   localparam int TH3      = 12;
   localparam int TH4      = 13;
   localparam int HYST     = 1;
   localparam int RAMP_DIV = 4;
`ifdef FAN_SPEED_CONT_OVERTEMP_EN
   localparam int OVT      = 15;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] temp;
   logic [3:0] fan_out;
`ifdef FAN_SPEED_CONT_OVERTEMP_EN
   logic       overtemp;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   int m_level;
   int m_cnt;
   int m_ovt;

   fan_speed_cont #(
      .TH1      (TH1),
      .TH2      (TH2),
      .TH3      (TH3),
      .TH4      (TH4),
      .HYST     (HYST),
      .RAMP_DIV (RAMP_DIV)
`ifdef FAN_SPEED_CONT_OVERTEMP_EN
      ,
      .OVT      (OVT)
`endif
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .temp     (temp),
      .fan_out  (fan_out)
`ifdef FAN_SPEED_CONT_OVERTEMP_EN
      ,
      .overtemp (overtemp)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Level leaves k only when temp < THk - HYST; rises as soon as temp >= THk.
   function automatic int ref_target(input int t, input int lvl);
      int th [5];
      int up;
      th = '{0, TH1, TH2, TH3, TH4};
      up = 0;
      for (int k = 1; k < 5; k++) if (t >= th[k]) up = k;
      if (up > lvl) return up;
      for (int k = lvl; k >= 0; k--) if (t + HYST >= th[k]) return k;
      return 0;
   endfunction

   function automatic logic [3:0] ref_therm(input int lvl);
      int v;
      v = (1 << lvl) - 1;
      return v[3:0];
   endfunction

   // One clock edge of the reference: count edges spent away from target,
   // take a step after RAMP_DIV of them.
   task automatic model_edge(input int t);
      int tg;
      tg = ref_target(t, m_level);
      if (tg == m_level) begin
         m_cnt = 0;
      end else begin
         m_cnt++;
         if (m_cnt == RAMP_DIV) begin
            m_level = (tg > m_level) ? m_level + 1 : m_level - 1;
            m_cnt   = 0;
         end
      end
`ifdef FAN_SPEED_CONT_OVERTEMP_EN
      m_ovt = (t >= OVT) ? 1 : 0;
      if (m_ovt != 0) begin
         m_level = 4;
         m_cnt   = 0;
      end
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(int'(temp));
      #1;
      check_val("model_fan", fan_out, ref_therm(m_level));
`ifdef FAN_SPEED_CONT_OVERTEMP_EN
      check_val("model_ovt", {3'b000, overtemp}, 4'(m_ovt));
`endif
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Asserts reset away from a clock edge and checks the asynchronous clear
   // before any further edge arrives.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      m_level = 0;
      m_cnt   = 0;
      m_ovt   = 0;
      check_val(tag, fan_out, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int hold;
      rst_n = 1'b0;
      temp  = 4'd0;
      m_level = 0;
      m_cnt   = 0;
      m_ovt   = 0;
      #1;
      check_val("rst_init", fan_out, 4'b0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // temp 7 never leaves level 0
      temp = 4'd7;
      steps(20);
      check_val("t7_level0", fan_out, 4'b0000);

      // temp 8: first step on edge 4
      do_reset("rst_t8");
      temp = 4'd8;
      steps(3);
      check_val("t8_edge3", fan_out, 4'b0000);
      steps(1);
      check_val("t8_edge4", fan_out, 4'b0001);
      temp = 4'd9;
      steps(10);
      check_val("t9_hold", fan_out, 4'b0001);

      // hysteresis around TH1
      temp = 4'd7;
      steps(20);
      check_val("hyst_t7", fan_out, 4'b0001);
      temp = 4'd6;
      steps(3);
      check_val("t6_edge3", fan_out, 4'b0001);
      steps(1);
      check_val("t6_edge4", fan_out, 4'b0000);

      // temp 13 ramps one level per four edges
      do_reset("rst_t13");
      temp = 4'd13;
      steps(4);  check_val("t13_e4",  fan_out, 4'b0001);
      steps(4);  check_val("t13_e8",  fan_out, 4'b0011);
      steps(4);  check_val("t13_e12", fan_out, 4'b0111);
      steps(4);  check_val("t13_e16", fan_out, 4'b1111);
      temp = 4'd14;
      steps(8);  check_val("t14_max", fan_out, 4'b1111);
      temp = 4'd15;
      steps(8);  check_val("t15_max", fan_out, 4'b1111);

      // hysteresis around TH3
      do_reset("rst_t12");
      temp = 4'd12;
      steps(12); check_val("t12_lvl3", fan_out, 4'b0111);
      temp = 4'd11;
      steps(12); check_val("t11_hold", fan_out, 4'b0111);
      temp = 4'd10;
      steps(4);  check_val("t10_down", fan_out, 4'b0011);
      steps(12); check_val("t10_hold", fan_out, 4'b0011);

      // reset mid-ramp, then the ramp restarts from level 0
      do_reset("rst_pre_mid");
      temp = 4'd13;
      steps(8);
      check_val("mid_lvl2", fan_out, 4'b0011);
      do_reset("rst_mid_ramp");
      steps(3);  check_val("mid_re_e3", fan_out, 4'b0000);
      steps(1);  check_val("mid_re_e4", fan_out, 4'b0001);

`ifdef FAN_SPEED_CONT_OVERTEMP_EN
      do_reset("rst_ovt");
      temp = 4'd15;
      steps(1);
      check_val("ovt_fan", fan_out, 4'b1111);
      check_val("ovt_set", {3'b000, overtemp}, 4'd1);
      temp = 4'd13;
      steps(1);
      check_val("ovt_clr", {3'b000, overtemp}, 4'd0);
      check_val("ovt_fan_hold", fan_out, 4'b1111);
`endif

      // randomized temp sequences with varied dwell times, mostly near the
      // thresholds, including reversals mid-ramp
      do_reset("rst_rand");
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) temp = 4'($urandom_range(0, 15));
         else                           temp = 4'($urandom_range(6, 14));
         hold = int'($urandom_range(1, 12));
         steps(hold);
         if ($urandom_range(0, 60) == 0) do_reset("rst_rand_mid");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
